// File: rtl/sum_accumulator.sv
// Block accumulator behind the 32-bit adder: sums BLOCK_LEN {cout,sum} results and
// presents the block total on a valid/ready port. Define SUM_ACC_SATURATE_EN to clamp on overflow.
module sum_accumulator #(
    parameter int DATA_W    = 32,
    parameter int ACC_W     = 40,
    parameter int BLOCK_LEN = 4,
    parameter int CNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_sum,
    input  logic              in_cout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic              out_ovf
);

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BLOCK_LEN - 1);

    state_t             state, state_next;
    logic [ACC_W-1:0]   acc, acc_next, out_acc_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic               ovf, ovf_next, out_ovf_next;
    logic [ACC_W-1:0]   sample;
    logic [ACC_W:0]     sum_ext;
    logic [ACC_W-1:0]   beat_acc;
    logic               beat_ovf;

    always_comb begin
        sample           = '0;
        sample[DATA_W:0] = {in_cout, in_sum};
    end

    // One extra bit catches the carry out of the accumulator's top bit.
    assign sum_ext  = {1'b0, acc} + {1'b0, sample};
    assign beat_ovf = ovf | sum_ext[ACC_W];

`ifdef SUM_ACC_SATURATE_EN
    assign beat_acc = beat_ovf ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
    assign beat_acc = sum_ext[ACC_W-1:0];
`endif

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == HOLD);

    always_comb begin
        state_next   = state;
        acc_next     = acc;
        cnt_next     = cnt;
        ovf_next     = ovf;
        out_acc_next = out_acc;
        out_ovf_next = out_ovf;
        // Clear outranks both handshakes, so a beat or total seen this cycle is dropped.
        if (clear) begin
            state_next = ACCUM;
            acc_next   = '0;
            cnt_next   = '0;
            ovf_next   = 1'b0;
        end else begin
            case (state)
                IDLE: state_next = ACCUM;
                ACCUM: begin
                    if (in_valid) begin
                        acc_next = beat_acc;
                        cnt_next = cnt + 1'b1;
                        ovf_next = beat_ovf;
                        if (cnt == LAST_BEAT) begin
                            state_next   = HOLD;
                            out_acc_next = beat_acc;
                            out_ovf_next = beat_ovf;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_next = ACCUM;
                        acc_next   = '0;
                        cnt_next   = '0;
                        ovf_next   = 1'b0;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            cnt     <= '0;
            ovf     <= 1'b0;
            out_acc <= '0;
            out_ovf <= 1'b0;
        end else begin
            acc     <= acc_next;
            cnt     <= cnt_next;
            ovf     <= ovf_next;
            out_acc <= out_acc_next;
            out_ovf <= out_ovf_next;
        end
    end

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench for sum_accumulator: a 40-bit instance and a 34-bit overflow instance
// share one stimulus stream and run in lockstep.
module tb_sum_accumulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        in_valid;
    logic [31:0] in_sum;
    logic        in_cout;
    logic        out_ready;

    logic        in_ready_a, out_valid_a, out_ovf_a;
    logic [39:0] out_acc_a;
    logic        in_ready_b, out_valid_b, out_ovf_b;
    logic [33:0] out_acc_b;

    int checks = 0;
    int errors = 0;

`ifdef SUM_ACC_SATURATE_EN
    localparam logic [33:0] EXP_OVF_ACC = 34'h3_FFFF_FFFF;
`else
    localparam logic [33:0] EXP_OVF_ACC = 34'h3_FFFF_FFFC;
`endif

    always #5 clk = ~clk;

    sum_accumulator #(.DATA_W(32), .ACC_W(40), .BLOCK_LEN(4), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_sum(in_sum), .in_cout(in_cout),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_acc(out_acc_a), .out_ovf(out_ovf_a)
    );

    sum_accumulator #(.DATA_W(32), .ACC_W(34), .BLOCK_LEN(4), .CNT_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_sum(in_sum), .in_cout(in_cout),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_acc(out_acc_b), .out_ovf(out_ovf_b)
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, then step to just after the rising edge.
    task automatic applyStimulus(input logic v, input logic [31:0] s, input logic c,
                                 input logic ordy, input logic clr);
        in_valid  = v;
        in_sum    = s;
        in_cout   = c;
        out_ready = ordy;
        clear     = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic sendBlock(input logic [31:0] s, input logic c);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, s, c, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid  = 1'($urandom);
            in_sum    = $urandom;
            in_cout   = 1'($urandom);
            out_ready = 1'($urandom);
            clear     = 1'($urandom);
            @(posedge clk);
            #1;
        end
        checkOutput("rst_in_ready", 64'(in_ready_a), 64'd0);
        checkOutput("rst_out_valid", 64'(out_valid_a), 64'd0);
        checkOutput("rst_out_acc", 64'(out_acc_a), 64'd0);
        checkOutput("rst_out_ovf", 64'(out_ovf_a), 64'd0);
        checkOutput("rst_out_acc_b", 64'(out_acc_b), 64'd0);

        rst_n = 1'b1;
        #1;
        checkOutput("ready_before_edge", 64'(in_ready_a), 64'd0);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("ready_after_release", 64'(in_ready_a), 64'd1);

        // Basic block 1+2+3+4
        applyStimulus(1'b1, 32'd1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'd2, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'd3, 1'b0, 1'b0, 1'b0);
        checkOutput("basic_valid_early", 64'(out_valid_a), 64'd0);
        applyStimulus(1'b1, 32'd4, 1'b0, 1'b0, 1'b0);
        checkOutput("basic_valid", 64'(out_valid_a), 64'd1);
        checkOutput("basic_acc", 64'(out_acc_a), 64'd10);
        checkOutput("basic_ovf", 64'(out_ovf_a), 64'd0);
        checkOutput("basic_ready", 64'(in_ready_a), 64'd0);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        checkOutput("basic_drain_valid", 64'(out_valid_a), 64'd0);
        checkOutput("basic_drain_ready", 64'(in_ready_a), 64'd1);

        // Carry path, and overflow on the 34-bit instance
        sendBlock(32'hFFFF_FFFF, 1'b1);
        checkOutput("carry_acc", 64'(out_acc_a), 64'h07_FFFF_FFFC);
        checkOutput("carry_ovf", 64'(out_ovf_a), 64'd0);
        checkOutput("ovf_valid_b", 64'(out_valid_b), 64'd1);
        checkOutput("ovf_ready_b", 64'(in_ready_b), 64'd0);
        checkOutput("ovf_acc_b", 64'(out_acc_b), 64'(EXP_OVF_ACC));
        checkOutput("ovf_flag_b", 64'(out_ovf_b), 64'd1);

        // Backpressure: inputs offered during HOLD must be ignored
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 32'd99, 1'b0, 1'b0, 1'b0);
            checkOutput("bp_acc_stable", 64'(out_acc_a), 64'h07_FFFF_FFFC);
            checkOutput("bp_ready", 64'(in_ready_a), 64'd0);
            checkOutput("bp_valid", 64'(out_valid_a), 64'd1);
        end
        applyStimulus(1'b1, 32'd99, 1'b0, 1'b1, 1'b0);
        checkOutput("bp_release_valid", 64'(out_valid_a), 64'd0);
        checkOutput("bp_release_ready", 64'(in_ready_a), 64'd1);
        sendBlock(32'd1, 1'b0);
        checkOutput("bp_next_acc", 64'(out_acc_a), 64'd4);
        checkOutput("bp_next_ovf_b", 64'(out_ovf_b), 64'd0);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);

        // Clear mid-block drops the partial sum and the beat presented with it
        applyStimulus(1'b1, 32'd7, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'd7, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'd7, 1'b0, 1'b0, 1'b1);
        checkOutput("clr_ready", 64'(in_ready_a), 64'd1);
        checkOutput("clr_valid", 64'(out_valid_a), 64'd0);
        sendBlock(32'd5, 1'b0);
        checkOutput("clr_acc", 64'(out_acc_a), 64'd20);
        checkOutput("clr_valid_after", 64'(out_valid_a), 64'd1);

        // Clear together with out_ready in HOLD discards the total
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
        checkOutput("clr_hold_valid", 64'(out_valid_a), 64'd0);
        checkOutput("clr_hold_ready", 64'(in_ready_a), 64'd1);
        sendBlock(32'd2, 1'b0);
        checkOutput("clr_hold_next_acc", 64'(out_acc_a), 64'd8);

        // Asynchronous reset during HOLD acts without a clock edge
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_hold_valid", 64'(out_valid_a), 64'd0);
        checkOutput("arst_hold_acc", 64'(out_acc_a), 64'd0);
        checkOutput("arst_hold_ready", 64'(in_ready_a), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("arst_rel_ready", 64'(in_ready_a), 64'd1);

        // Asynchronous reset mid-block discards the partial sum
        applyStimulus(1'b1, 32'd3, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'd3, 1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_mid_ready", 64'(in_ready_a), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        sendBlock(32'd1, 1'b0);
        checkOutput("arst_mid_acc", 64'(out_acc_a), 64'd4);
        checkOutput("arst_mid_valid", 64'(out_valid_a), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sum_accumulator.md
# sum_accumulator

Block accumulator placed directly downstream of the 32-bit adder. It consumes one `{Cout, sum}` result per handshake and adds it, as an unsigned 33-bit value, into a wide accumulator. After `BLOCK_LEN` accepted results it presents the block total on a valid/ready output port, then restarts from zero. It is the first clocked stage after the combinational adder datapath.

## Interface
- `DATA_W`, 32, width of the adder sum input
- `ACC_W`, 40, accumulator/output width; must be ≥ `DATA_W`+1
- `BLOCK_LEN`, 4, results summed per output block; ≥ 1, ≤ 2^`CNT_W`
- `CNT_W`, 8, beat-counter width
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `clear`  in  1  synchronous abort: zero accumulator, restart block
- `in_valid`  in  1  adder result present
- `in_ready`  out  1  block accepts result this cycle
- `in_sum`  in  `DATA_W`  adder sum
- `in_cout`  in  1  adder carry-out
- `out_valid`  out  1  block total available
- `out_ready`  in  1  consumer takes total
- `out_acc`  out  `ACC_W`  block total
- `out_ovf`  out  1  sticky: accumulator overflowed during this block

## Operation
- The sample is `{in_cout, in_sum}`, zero-extended to `ACC_W`. It is unsigned.
- The block is a 3-state FSM:
  - IDLE → ACCUM unconditionally on the first edge after reset release.
  - In ACCUM, `in_ready`=1. A beat is accepted when `in_valid`&&`in_ready`: `acc`←`acc`+sample and `cnt`←`cnt`+1. If `cnt`==`BLOCK_LEN`-1 at acceptance, the state goes to HOLD, `out_acc`←`acc`+sample, and `out_ovf` takes the final flag.
  - In HOLD, `out_valid`=1 and `in_ready`=0. On `out_ready`: `acc`, `cnt` and the overflow flag go to 0, and the state goes to ACCUM.
- `in_ready` and `out_valid` are decoded from registered state only. There is no combinational path from `in_valid` or `out_ready`.
- Overflow: a carry out of bit `ACC_W`-1 sets the sticky flag. Without the macro, the sum wraps modulo 2^`ACC_W`.
- `clear` has the highest priority over every handshake, including a simultaneous input or output handshake:
  - `acc`, `cnt` and the flag go to 0.
  - The state goes to ACCUM; from IDLE it still goes to ACCUM.
  - `out_valid` drops, any pending total is discarded, and a beat presented that cycle is dropped.
- `in_sum` and `in_cout` are ignored when no handshake occurs.
- `out_acc` and `out_ovf` stay stable throughout HOLD. Outside HOLD they hold their last value and are don't-care.

## Timing
- Reset (asynchronous, `rst_n`=0):
  - State is IDLE.
  - `in_ready`=0, `out_valid`=0, `out_acc`=0, `out_ovf`=0.
  - Internal `acc`=0 and `cnt`=0.
- `in_ready` rises on the first rising edge after `rst_n` deasserts.
- Throughput is 1 beat per cycle in ACCUM.
- Latency: when the final beat is accepted at edge k, `out_valid`=1 after edge k.
- No input is accepted during HOLD. `in_ready` returns to 1 the cycle after the output handshake edge. Block period is ≥ `BLOCK_LEN`+1 cycles.
- Reset mid-block or during HOLD discards everything immediately, without waiting for a clock edge.
- `BLOCK_LEN`=1: every accepted beat goes straight to HOLD.

## Configuration
- `SUM_ACC_SATURATE_EN` defined: on overflow the accumulator clamps to 2^`ACC_W`-1 and stays there for the rest of the block. `out_ovf` is still set.
- `SUM_ACC_SATURATE_EN` undefined: the accumulator wraps modulo 2^`ACC_W` and `out_ovf` is set.

## Test plan
- Reset: `rst_n`=0 with random inputs → `in_ready`=0, `out_valid`=0, `out_acc`=0, `out_ovf`=0. One edge after release → `in_ready`=1.
- Basic (`BLOCK_LEN`=4): back-to-back beats with sum 1, 2, 3, 4 and cout 0 → `out_valid`=1 the cycle after the 4th edge, `out_acc`=10, `out_ovf`=0, `in_ready`=0.
- Carry path: 4 beats with `in_sum`=32'hFFFFFFFF, `in_cout`=1 → `out_acc`=40'h07_FFFF_FFFC, `out_ovf`=0.
- Overflow (`ACC_W`=34): the same 4 beats → wrap build `out_acc`=34'h3_FFFF_FFFC, `out_ovf`=1. With `SUM_ACC_SATURATE_EN` → 34'h3_FFFF_FFFF, `out_ovf`=1.
- Backpressure: hold `out_ready`=0 for 5 cycles while `in_valid`=1 with sum 99 → `out_acc` stays stable, `in_ready`=0, nothing is accepted. Raise `out_ready` → the next block of four 1s yields 4.
- Clear: 2 beats of 7, then `clear` pulsed together with a beat of 7, then 4 beats of 5 → `out_acc`=20. Separately, `clear` asserted together with `out_ready` in HOLD → total discarded and `out_valid`=0 next cycle.
